// File: rtl/inst_rom.sv
// inst_rom: instruction memory for the CPU fetch port, with a byte-serial program loader.
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   ce, addr, inst  fetch request (byte address) and combinational instruction word
//   load_start      pulse that begins a download
//   ld_valid, ld_byte, ld_last, ld_ready   loader byte handshake
//   loading, load_done, load_err, load_count   loader status
module inst_rom #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst,
    input  logic                  load_start,
    input  logic                  ld_valid,
    input  logic [7:0]            ld_byte,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  loading,
    output logic                  load_done,
    output logic                  load_err,
    output logic [DEPTH_LOG2:0]   load_count
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, LOAD, FULL, DONE} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            bcnt_q;
    logic [23:0]           acc_q;      // bytes received so far, left-aligned
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  wr_en;
    logic [31:0]           word;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

    // Fetch path: zero-latency read, masked while a download owns the array.
    assign inst = (ce && !loading) ? mem[addr[DEPTH_LOG2+1:2]] : 32'h0;

    // Next state and loader datapath controls.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        wr_en   = 1'b0;
        // Merge the incoming byte into its big-endian lane; lower lanes read as zero padding.
        case (bcnt_q)
            2'd0:    word = {ld_byte, 24'h0};
            2'd1:    word = {acc_q[23:16], ld_byte, 16'h0};
            2'd2:    word = {acc_q[23:8], ld_byte, 8'h0};
            default: word = {acc_q, ld_byte};
        endcase
        case (state_q)
            IDLE: begin
                if (load_start) state_d = LOAD;
            end
            LOAD: begin
                accept = ld_valid;
                if (accept) begin
                    wr_en = (bcnt_q == 2'd3) || ld_last;
                    if (ld_last)
                        state_d = DONE;
                    else if (wr_en && (load_count == CW'(DEPTH - 1)))
                        state_d = FULL;
                end
            end
            FULL: begin
                accept = ld_valid;
                if (accept && ld_last) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            bcnt_q     <= 2'd0;
            acc_q      <= 24'h0;
            wptr_q     <= '0;
            ld_ready   <= 1'b0;
            loading    <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            load_count <= '0;
        end else begin
            state_q   <= state_d;
            ld_ready  <= (state_d == LOAD) || (state_d == FULL);
            loading   <= (state_d == LOAD) || (state_d == FULL);
            load_done <= (state_d == DONE);
            if ((state_q == IDLE) && load_start) begin
                bcnt_q     <= 2'd0;
                wptr_q     <= '0;
                load_count <= '0;
                load_err   <= 1'b0;
            end
            if ((state_q == LOAD) && accept) begin
                acc_q  <= word[31:8];
                bcnt_q <= bcnt_q + 2'd1;
                if (wr_en) begin
                    bcnt_q     <= 2'd0;
                    wptr_q     <= wptr_q + DEPTH_LOG2'(1);
                    load_count <= load_count + CW'(1);
                end
            end
            if ((state_q == FULL) && accept) load_err <= 1'b1;
        end
    end

    // Memory array: no reset, contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && wr_en) mem[wptr_q] <= word;
    end

endmodule

// File: tb/tb_inst_rom.sv
// tb_inst_rom: self-checking bench for inst_rom (directed tables plus randomized downloads).
module tb_inst_rom;
    localparam int unsigned DL = 10;
    localparam int unsigned DEPTH = 1 << DL;

    logic        clk;
    logic        rst;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        load_start;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        loading;
    logic        load_done;
    logic        load_err;
    logic [DL:0] load_count;

    inst_rom #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst),
        .load_start(load_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_last(ld_last), .ld_ready(ld_ready), .loading(loading),
        .load_done(load_done), .load_err(load_err), .load_count(load_count)
    );

    typedef struct {
        logic        ce;
        logic [31:0] addr;
        logic [31:0] exp;
    } fvec_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [DEPTH];
    logic [7:0]  bq [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch(input string name, input logic c, input logic [31:0] a, input logic [31:0] exp);
        ce   = c;
        addr = a;
        #1;
        check(name, inst, exp);
    endtask

    // Offer one byte and wait (bounded) for the handshake to complete.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int w = 0;
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        while (!ld_ready && w < 8) begin
            tick();
            w++;
        end
        check("ld_ready during download", 32'(ld_ready), 32'd1);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    // Download the bytes in bq, check status, then update the reference model.
    task automatic download(input bit gaps, input string tag);
        int n = bq.size();
        int nw;
        logic [31:0] w;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check({tag, " loading after start"}, 32'(loading), 32'd1);
        fetch({tag, " fetch masked while loading"}, 1'b1, 32'h4, 32'h0);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                ld_valid = 1'b0;
                ld_byte  = 8'hFF;
                ld_last  = 1'b1;
                tick();
            end
            send_byte(bq[i], i == n - 1);
        end
        check({tag, " load_done pulse"}, 32'(load_done), 32'd1);
        check({tag, " loading in done"}, 32'(loading), 32'd0);
        check({tag, " ld_ready in done"}, 32'(ld_ready), 32'd0);
        tick();
        check({tag, " load_done single cycle"}, 32'(load_done), 32'd0);
        nw = (n + 3) / 4;
        if (nw > DEPTH) nw = DEPTH;
        check({tag, " load_count"}, 32'(load_count), 32'(nw));
        check({tag, " load_err"}, 32'(load_err), (n > 4 * DEPTH) ? 32'd1 : 32'd0);
        for (int k = 0; k < nw; k++) model[k] = 32'h0;
        for (int i = 0; i < n; i++) begin
            if (i / 4 < DEPTH) begin
                w = model[i / 4];
                w[8 * (3 - (i % 4)) +: 8] = bq[i];
                model[i / 4] = w;
            end
        end
    endtask

    initial begin
        fvec_t       tbl [8];
        logic [31:0] first_word;
        logic [31:0] old1;
        logic [31:0] a;
        logic        c;

        tbl[0] = '{1'b1, 32'h0000_0000, 32'h3401_0001};
        tbl[1] = '{1'b1, 32'h0000_0004, 32'h3402_0002};
        tbl[2] = '{1'b1, 32'h0000_0005, 32'h3402_0002};
        tbl[3] = '{1'b1, 32'h0000_0007, 32'h3402_0002};
        tbl[4] = '{1'b0, 32'h0000_0004, 32'h0000_0000};
        tbl[5] = '{1'b1, 32'h0000_1004, 32'h3402_0002};
        tbl[6] = '{1'b1, 32'h0000_1000, 32'h3401_0001};
        tbl[7] = '{1'b1, 32'hFFFF_F004, 32'h3402_0002};

        rst = 1'b0; ce = 1'b0; addr = 32'h0; load_start = 1'b0;
        ld_valid = 1'b0; ld_byte = 8'h0; ld_last = 1'b0;
        tick();
        tick();
        check("reset ld_ready", 32'(ld_ready), 32'd0);
        check("reset loading", 32'(loading), 32'd0);
        check("reset load_done", 32'(load_done), 32'd0);
        check("reset load_err", 32'(load_err), 32'd0);
        check("reset load_count", 32'(load_count), 32'd0);
        rst = 1'b1;
        tick();

        // Scenario 1: two-word program.
        bq = '{8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02};
        download(1'b0, "s1");
        fetch("s1 addr0", 1'b1, 32'h0, 32'h3401_0001);
        fetch("s1 addr4", 1'b1, 32'h4, 32'h3402_0002);
        fetch("s1 addr5", 1'b1, 32'h5, 32'h3402_0002);
        tick();
        tick();
        check("s1 load_count held", 32'(load_count), 32'd2);

        // Scenario 2: partial final word is zero padded.
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        download(1'b0, "s2");
        fetch("s2 mem0", 1'b1, 32'h0, 32'hAABB_CCDD);
        fetch("s2 mem1", 1'b1, 32'h4, 32'hEE00_0000);

        // Scenario 3: bytes in IDLE ignored, then download with valid gaps.
        ld_valid = 1'b1; ld_byte = 8'h55; ld_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s3 ld_ready idle", 32'(ld_ready), 32'd0);
            check("s3 loading idle", 32'(loading), 32'd0);
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        bq = '{8'h34, 8'h01, 8'h00, 8'h01, 8'h34, 8'h02, 8'h00, 8'h02};
        download(1'b1, "s3");

        // Scenario 4: fetch table (ce gating, low-bit and high-bit address wrap).
        for (int i = 0; i < 8; i++)
            fetch($sformatf("s4 table %0d", i), tbl[i].ce, tbl[i].addr, tbl[i].exp);

        // Scenario 5: overflow the memory depth.
        bq.delete();
        for (int i = 0; i < 4 * DEPTH + 4; i++) bq.push_back(8'($urandom));
        first_word = {bq[0], bq[1], bq[2], bq[3]};
        download(1'b0, "s5");
        fetch("s5 mem0 first word", 1'b1, 32'h0, first_word);
        fetch("s5 last word", 1'b1, 32'((DEPTH - 1) * 4), model[DEPTH - 1]);

        // Scenario 6: reset after six accepted bytes.
        old1 = model[1];
        bq.delete();
        for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(bq[i], 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("s6 loading after reset", 32'(loading), 32'd0);
        check("s6 load_count after reset", 32'(load_count), 32'd0);
        check("s6 ld_ready after reset", 32'(ld_ready), 32'd0);
        check("s6 load_done after reset", 32'(load_done), 32'd0);
        model[0] = {bq[0], bq[1], bq[2], bq[3]};
        fetch("s6 mem0 written", 1'b1, 32'h0, model[0]);
        fetch("s6 mem1 unchanged", 1'b1, 32'h4, old1);
        tick();

        // Randomized downloads and fetches against the reference model.
        for (int r = 0; r < 6; r++) begin
            bq.delete();
            for (int i = 0; i < 1 + $urandom_range(39); i++) bq.push_back(8'($urandom));
            download(1'($urandom), $sformatf("rnd%0d", r));
            for (int f = 0; f < 20; f++) begin
                a = $urandom;
                if (f < 10) a[31:2] = 30'($urandom_range(11));
                c = 1'($urandom_range(3) != 0);
                fetch($sformatf("rnd%0d fetch %h", r, a), c, a, c ? model[a[DL+1:2]] : 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/inst_rom.md
Name: inst_rom

Overview:
- Instruction memory responder on the CPU fetch side: answers fetch requests (ce, addr) from the core's pc stage with the addressed 32-bit instruction word.
- Also contains a byte-serial program loader (valid/ready handshake) that assembles bytes into big-endian words and writes them sequentially from word 0.
- Sits beside the core at top level. Its fetch port connects to rom_ce_o/rom_addr_o/rom_data_i, and its loader port connects to the bench or host download path.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (1024 words)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets at the next rising clk edge)
ce  input  1  fetch enable from core
addr  input  32  fetch byte address from core
inst  output  32  instruction word to core
load_start  input  1  single-cycle pulse; begin a program download
ld_valid  input  1  loader byte valid
ld_byte  input  8  loader byte
ld_last  input  1  qualifies the byte as the final byte of the program
ld_ready  output  1  loader may accept a byte this cycle
loading  output  1  download in progress
load_done  output  1  one-cycle pulse at end of download
load_err  output  1  sticky: download overflowed the memory depth
load_count  output  DEPTH_LOG2+1  words written by the last/current download

Behaviour:
- Fetch path is combinational, with zero-cycle latency: inst = mem[addr[DEPTH_LOG2+1:2]] when ce==1 and loading==0; otherwise inst = 0.
- addr[1:0] is ignored. Upper address bits beyond the index are ignored, so the index wraps modulo depth.
- Memory array is not reset and keeps its contents across reset.
- Reset values: ld_ready=0, loading=0, load_done=0, load_err=0, load_count=0, FSM=IDLE, byte counter=0, word pointer=0.
- FSM states:
  - IDLE: ld_ready=0, loading=0. On load_start: go to LOAD, clear word pointer, byte counter, load_count and load_err.
  - LOAD: ld_ready=1, loading=1. A byte is accepted when ld_valid && ld_ready.
    - Bytes are big-endian: byte 0 of a word goes to [31:24], byte 3 to [7:0].
    - On acceptance of byte 3, write mem[wptr] on that edge, then increment wptr and load_count.
    - If ld_last is accepted with byte k<3, the remaining bytes are zero-padded and the word is written on the same edge.
    - Either way, ld_last causes the transition to DONE.
    - If a write makes load_count == 2^DEPTH_LOG2 without ld_last, go to FULL.
  - FULL: ld_ready=1, loading=1. Accepted bytes are discarded and load_err is set. Exit to DONE when ld_last is accepted.
  - DONE: load_done=1 for exactly one cycle, ld_ready=0, loading=0. Next state is IDLE.
- load_start is ignored in LOAD, FULL and DONE.
- A load_start with no following bytes stays in LOAD indefinitely, with fetch returning 0.
- A write and a fetch never collide, because fetch is masked while loading==1.
- If reset asserts mid-download, the FSM returns to IDLE and all counters and outputs take their reset values. Words already written remain in memory. A partially assembled word is discarded.
- load_count and load_err hold their values after DONE until the next load_start or reset.

Test Plan:
1. Reset then download 8 bytes 34,01,00,01, 34,02,00,02 with ld_last on the 8th byte, then fetch with ce=1.
   - Required: load_count=2 and load_done pulses for one cycle.
   - Required: addr 0x0 gives inst=0x34010001, addr 0x4 gives 0x34020002, addr 0x5 gives 0x34020002.
2. Download 5 bytes AA,BB,CC,DD,EE with ld_last on the 5th.
   - Required: mem[0]=0xAABBCCDD, mem[1]=0xEE000000, load_count=2.
3. Drive ld_valid low on alternate cycles during a download.
   - Required: only handshaked bytes are assembled, with the same result as scenario 1.
   - Required: ld_ready=0 in IDLE, and bytes driven while in IDLE are ignored.
4. Drive ce=0 or loading=1 with addr=0x4.
   - Required: inst=0.
   - Required: addr=0x1004 (with DEPTH_LOG2=10) returns mem[1].
5. Stream 4*1024+4 bytes with ld_last on the last byte.
   - Required: load_count=1024, load_err=1, load_done pulses.
   - Required: mem[0] holds the first word and is not overwritten by the extra bytes.
6. Drive rst=0 for one cycle after 6 accepted bytes, then fetch addr 0x0.
   - Required: mem[0] holds the first word, mem[1] is unchanged, and loading=0, load_count=0, ld_ready=0.
